bp_me_dma_responder: RTL and testbench
======================================

// Module: bp_me_dma_responder
// PURPOSE
//  Backing-store responder for the bsg_cache DMA interface: the DRAM-side end of the L2 dma_pkt/dma_data channels.
//  Accepts one block read/write packet at a time, streams fill beats back on reads, absorbs evict beats on writes.
//  Holds an internal register-array memory; used as the DRAM model under unicore/multicore testbenches and FPGA shells.
// PARAMETERS
//  addr_width_p          28    byte address width of dma_pkt (caddr_width_p)
//  data_width_p          64    DMA beat width in bits (l2_fill_width_p); power of 2, >=8
//  beats_per_block_p     8     beats per cache block transfer; power of 2
//  mem_els_p             1024  storage depth in beats; power of 2, multiple of beats_per_block_p
//  read_latency_p        4     idle cycles between read packet accept and first read beat; 0 allowed
//  dma_pkt_width_lp      addr_width_p+1 (derived) packet = {write_not_read, addr}
// PORTS
//  clk_i            in   1               clock
//  reset_n_i        in   1               asynchronous active-low reset
//  dma_pkt_i        in   dma_pkt_width_lp  {write_not_read[MSB], byte addr}
//  dma_pkt_v_i      in   1               packet valid
//  dma_pkt_yumi_o   out  1               packet consumed this cycle
//  dma_data_o       out  data_width_p    read (fill) beat to cache
//  dma_data_v_o     out  1               read beat valid
//  dma_data_ready_and_i in 1             cache accepts read beat
//  dma_data_i       in   data_width_p    write (evict) beat from cache
//  dma_data_v_i     in   1               write beat valid
//  dma_data_yumi_o  out  1               write beat consumed this cycle
// BEHAVIOUR
//  - One clock; reset_n_i asynchronous active-low. During reset: state=IDLE, beat/latency counters=0,
//    all v/yumi outputs 0, dma_data_o=0. Memory array is NOT reset (contents X until written).
//  - Index: beat_idx = addr >> log2(data_width_p/8); block base = beat_idx with low log2(beats_per_block_p) bits
//    cleared; storage index = (base + beat_cnt) mod mem_els_p. Addresses beyond capacity alias (wrap) silently.
//    Sub-block address bits are ignored; every transfer covers a whole aligned block, beats in ascending order.
//  - FSM states: IDLE, LATENCY, READ, WRITE.
//   IDLE: dma_pkt_yumi_o = dma_pkt_v_i (combinational, only in IDLE). On yumi register base and write_not_read;
//    write -> WRITE; read -> LATENCY if read_latency_p>0 else READ. beat_cnt cleared.
//   LATENCY: counts read_latency_p cycles, then READ. Packet accept at cycle T => first dma_data_v_o at T+read_latency_p+1.
//   READ: dma_data_v_o=1, dma_data_o=mem[base+beat_cnt] (combinational read). Data held stable while ready_and_i=0.
//    On v&ready: beat_cnt++; on last beat (beat_cnt==beats_per_block_p-1) -> IDLE.
//   WRITE: dma_data_yumi_o = dma_data_v_i; on yumi write mem[base+beat_cnt] at clock edge, beat_cnt++;
//    after last beat -> IDLE.
//  - dma_data_v_o=0 and dma_data_o=0 outside READ; dma_data_yumi_o=0 outside WRITE; dma_pkt_yumi_o=0 outside IDLE.
//  - Exactly one packet outstanding: no new packet accepted until the prior block completes; next accept is the
//    cycle after the last beat at the earliest (IDLE-to-IDLE turnaround of one cycle).
//  - Read-after-write to the same block returns the written data (write completes before IDLE).
//  - Write beats arriving in IDLE/LATENCY/READ are ignored (not consumed). ready_and_i outside READ has no effect.
//  - Reset mid-operation: transfer aborted, FSM to IDLE; beats already written remain in memory.
//  - beat_cnt width = log2(beats_per_block_p); wraps to 0 exactly on block completion.
// TESTING
//  1 write pkt {1,0x0040}, 8 beats 0x11..0x88 with v held high -> yumi each cycle, 8 cycles, FSM back to IDLE.
//  2 read pkt {0,0x0040}, latency 4, ready high -> v_o first at T+5, beats 0x11..0x88 in order on 8 consecutive cycles.
//  3 read with ready_and_i toggled 1,0,0,1... -> dma_data_o unchanged while ready low; all 8 beats delivered once.
//  4 aliasing: write block at 0x0040, read {0,0x2040} (8 KiB storage) -> same 0x11..0x88 data.
//  5 pkt_v held high during a write transfer -> pkt_yumi stays 0 until cycle after last beat, then 1.
//  6 assert reset_n_i low at beat 3 of a read -> v_o drops immediately; after release, IDLE, next pkt accepted normally.

Source files
------------

// File: rtl/bp_me_dma_responder.sv
// ---------------------------------------------------------------------------
// bp_me_dma_responder
//
// DRAM-side responder for the bsg_cache DMA channels. Accepts one block
// read or write packet at a time. Reads stream a whole aligned block of fill
// beats back to the cache after a fixed latency. Writes absorb a whole
// aligned block of evict beats. Storage is an internal register array that
// has no reset. Addresses beyond the array capacity wrap silently.
//
// Ports:
//   clk_i                 clock
//   reset_n_i             asynchronous active-low reset
//   dma_pkt_i             {write_not_read, byte address}
//   dma_pkt_v_i           packet valid
//   dma_pkt_yumi_o        packet consumed this cycle (IDLE only)
//   dma_data_o            read (fill) beat to the cache, zero outside READ
//   dma_data_v_o          read beat valid
//   dma_data_ready_and_i  cache accepts the read beat
//   dma_data_i            write (evict) beat from the cache
//   dma_data_v_i          write beat valid
//   dma_data_yumi_o       write beat consumed this cycle (WRITE only)
// ---------------------------------------------------------------------------
module bp_me_dma_responder #(
   parameter int addr_width_p      = 28,
   parameter int data_width_p      = 64,
   parameter int beats_per_block_p = 8,
   parameter int mem_els_p         = 1024,
   parameter int read_latency_p    = 4,
   parameter int dma_pkt_width_lp  = addr_width_p + 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,

   input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
   input  logic                        dma_pkt_v_i,
   output logic                        dma_pkt_yumi_o,

   output logic [data_width_p-1:0]     dma_data_o,
   output logic                        dma_data_v_o,
   input  logic                        dma_data_ready_and_i,

   input  logic [data_width_p-1:0]     dma_data_i,
   input  logic                        dma_data_v_i,
   output logic                        dma_data_yumi_o
);

   localparam int byte_off_lp  = $clog2(data_width_p / 8);
   localparam int blk_off_lp   = $clog2(beats_per_block_p);
   localparam int idx_width_lp = $clog2(mem_els_p);
   localparam int cnt_width_lp = (blk_off_lp > 0) ? blk_off_lp : 1;
   localparam int lat_width_lp = (read_latency_p > 0) ? $clog2(read_latency_p + 1) : 1;

   localparam logic [idx_width_lp-1:0] blk_mask_lp  = idx_width_lp'(beats_per_block_p - 1);
   localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(beats_per_block_p - 1);
   localparam logic [lat_width_lp-1:0] last_lat_lp  = lat_width_lp'(read_latency_p - 1);

   typedef enum logic [1:0] {
      IDLE,
      LATENCY,
      READ,
      WRITE
   } state_e;

   state_e                    state_r, state_n;
   logic [cnt_width_lp-1:0]   beat_cnt_r, beat_cnt_n;
   logic [lat_width_lp-1:0]   lat_cnt_r, lat_cnt_n;
   logic [idx_width_lp-1:0]   base_r, base_n;

   logic                      pkt_write;
   logic [idx_width_lp-1:0]   pkt_base;
   logic [idx_width_lp-1:0]   mem_idx;
   logic                      pkt_unused;

   logic [data_width_p-1:0]   mem_r [mem_els_p];

   // Only the beat-index bits that fit in storage matter; the byte offset,
   // the sub-block offset and the bits above capacity are dropped, which is
   // what makes out-of-range addresses alias and transfers block-aligned.
   assign pkt_write  = dma_pkt_i[addr_width_p];
   assign pkt_base   = dma_pkt_i[byte_off_lp +: idx_width_lp] & ~blk_mask_lp;
   assign pkt_unused = ^dma_pkt_i;

   // Base is block-aligned, so adding the beat count never carries out of
   // the block; truncation to the index width gives the mod-capacity wrap.
   assign mem_idx = base_r + idx_width_lp'(beat_cnt_r);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r    <= IDLE;
         beat_cnt_r <= '0;
         lat_cnt_r  <= '0;
         base_r     <= '0;
      end else begin
         state_r    <= state_n;
         beat_cnt_r <= beat_cnt_n;
         lat_cnt_r  <= lat_cnt_n;
         base_r     <= base_n;
      end
   end

   // Storage has no reset. A write can only happen in WRITE, and reset
   // forces IDLE asynchronously, so no beat lands while reset is held.
   always_ff @(posedge clk_i) begin
      if (dma_data_yumi_o) begin
         mem_r[mem_idx] <= dma_data_i;
      end
   end

   always_comb begin
      state_n         = state_r;
      beat_cnt_n      = beat_cnt_r;
      lat_cnt_n       = lat_cnt_r;
      base_n          = base_r;
      dma_pkt_yumi_o  = 1'b0;
      dma_data_v_o    = 1'b0;
      dma_data_o      = '0;
      dma_data_yumi_o = 1'b0;

      unique case (state_r)
         IDLE: begin
            // Gated by reset so the handshake stays quiet while reset is held,
            // even though the FSM already sits in IDLE.
            dma_pkt_yumi_o = dma_pkt_v_i & reset_n_i;
            if (dma_pkt_yumi_o) begin
               base_n     = pkt_base;
               beat_cnt_n = '0;
               lat_cnt_n  = '0;
               if (pkt_write) begin
                  state_n = WRITE;
               end else if (read_latency_p > 0) begin
                  state_n = LATENCY;
               end else begin
                  state_n = READ;
               end
            end
         end

         LATENCY: begin
            if (lat_cnt_r == last_lat_lp) begin
               lat_cnt_n = '0;
               state_n   = READ;
            end else begin
               lat_cnt_n = lat_cnt_r + lat_width_lp'(1);
            end
         end

         READ: begin
            dma_data_v_o = 1'b1;
            dma_data_o   = mem_r[mem_idx];
            if (dma_data_ready_and_i) begin
               if (beat_cnt_r == last_beat_lp) begin
                  beat_cnt_n = '0;
                  state_n    = IDLE;
               end else begin
                  beat_cnt_n = beat_cnt_r + cnt_width_lp'(1);
               end
            end
         end

         WRITE: begin
            dma_data_yumi_o = dma_data_v_i;
            if (dma_data_v_i) begin
               if (beat_cnt_r == last_beat_lp) begin
                  beat_cnt_n = '0;
                  state_n    = IDLE;
               end else begin
                  beat_cnt_n = beat_cnt_r + cnt_width_lp'(1);
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bp_me_dma_responder.sv
// ---------------------------------------------------------------------------
// tb_bp_me_dma_responder
//
// Directed self-checking bench for bp_me_dma_responder with default
// parameters (64-bit beats, 8 beats per block, 1024-beat store = 8 KiB,
// read latency 4). Each test task drives its own stimulus and compares
// the DUT outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bp_me_dma_responder;

   localparam int AW = 28;
   localparam int DW = 64;
   localparam int PW = AW + 1;

   logic          clk_i;
   logic          reset_n_i;
   logic [PW-1:0] dma_pkt_i;
   logic          dma_pkt_v_i;
   logic          dma_pkt_yumi_o;
   logic [DW-1:0] dma_data_o;
   logic          dma_data_v_o;
   logic          dma_data_ready_and_i;
   logic [DW-1:0] dma_data_i;
   logic          dma_data_v_i;
   logic          dma_data_yumi_o;

   int checks;
   int errors;

   bp_me_dma_responder dut (
      .clk_i                (clk_i),
      .reset_n_i            (reset_n_i),
      .dma_pkt_i            (dma_pkt_i),
      .dma_pkt_v_i          (dma_pkt_v_i),
      .dma_pkt_yumi_o       (dma_pkt_yumi_o),
      .dma_data_o           (dma_data_o),
      .dma_data_v_o         (dma_data_v_o),
      .dma_data_ready_and_i (dma_data_ready_and_i),
      .dma_data_i           (dma_data_i),
      .dma_data_v_i         (dma_data_v_i),
      .dma_data_yumi_o      (dma_data_yumi_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Block at 0x0040 holds 0x11..0x88, block at 0x0080 holds 0xA0..0xA7.
   function automatic logic [DW-1:0] blk40(input int i);
      return DW'(64'h11 * (i + 1));
   endfunction

   function automatic logic [DW-1:0] blk80(input int i);
      return DW'(64'hA0 + i);
   endfunction

   // Advance to just after the next rising edge; inputs change here.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_n_i            = 1'b0;
      dma_pkt_i            = {1'b0, 28'h40};
      dma_pkt_v_i          = 1'b1;
      dma_data_ready_and_i = 1'b1;
      dma_data_i           = 64'hDEAD;
      dma_data_v_i         = 1'b1;
      step();
      step();
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pkt_yumi got %b want 0", dma_pkt_yumi_o);
      end
      checks++;
      if (dma_data_v_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_data_v got %b want 0", dma_data_v_o);
      end
      checks++;
      if (dma_data_o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data got %h want 0", dma_data_o);
      end
      checks++;
      if (dma_data_yumi_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_data_yumi got %b want 0", dma_data_yumi_o);
      end
      dma_pkt_v_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      step();
      #1;
      // Out of reset in IDLE: a stray write beat is not consumed.
      checks++;
      if (dma_data_yumi_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_data_yumi got %b want 0", dma_data_yumi_o);
      end
      dma_data_v_i = 1'b0;
   endtask

   task automatic test_write_block();
      step();
      dma_pkt_i   = {1'b1, 28'h40};
      dma_pkt_v_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wr_pkt_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         dma_pkt_v_i  = 1'b0;
         dma_data_i   = blk40(i);
         dma_data_v_i = 1'b1;
         #1;
         checks++;
         if (dma_data_yumi_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_beat%0d_yumi got %b want 1", i, dma_data_yumi_o);
         end
      end
      step();
      dma_data_i = 64'hBAD0;
      #1;
      checks++;
      if (dma_data_yumi_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_done_yumi got %b want 0", dma_data_yumi_o);
      end
      dma_data_v_i = 1'b0;
   endtask

   task automatic test_read_latency();
      step();
      dma_pkt_i            = {1'b0, 28'h40};
      dma_pkt_v_i          = 1'b1;
      dma_data_ready_and_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rd_pkt_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i = 1'b0;
         #1;
         checks++;
         if (dma_data_v_o !== 1'b0 || dma_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL rd_lat%0d got v=%b d=%h want v=0 d=0", k, dma_data_v_o, dma_data_o);
         end
      end
      for (int i = 0; i < 8; i++) begin
         step();
         #1;
         checks++;
         if (dma_data_v_o !== 1'b1 || dma_data_o !== blk40(i)) begin
            errors++;
            $display("[TB] FAIL rd_beat%0d got v=%b d=%h want v=1 d=%h", i, dma_data_v_o, dma_data_o, blk40(i));
         end
      end
      step();
      #1;
      checks++;
      if (dma_data_v_o !== 1'b0 || dma_data_o !== '0) begin
         errors++;
         $display("[TB] FAIL rd_done got v=%b d=%h want v=0 d=0", dma_data_v_o, dma_data_o);
      end
   endtask

   task automatic test_read_backpressure();
      int exp_idx;
      int cyc;
      exp_idx = 0;
      cyc     = 0;
      step();
      dma_pkt_i   = {1'b0, 28'h40};
      dma_pkt_v_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_pkt_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i          = 1'b0;
         dma_data_ready_and_i = 1'b0;
      end
      // Ready follows 1,0,0,1 repeating; a beat advances only when ready.
      while (exp_idx < 8 && cyc < 40) begin
         step();
         dma_data_ready_and_i = (cyc % 4 == 0) || (cyc % 4 == 3);
         #1;
         checks++;
         if (dma_data_v_o !== 1'b1 || dma_data_o !== blk40(exp_idx)) begin
            errors++;
            $display("[TB] FAIL bp_cyc%0d got v=%b d=%h want v=1 d=%h", cyc, dma_data_v_o, dma_data_o, blk40(exp_idx));
         end
         if (dma_data_ready_and_i) exp_idx++;
         cyc++;
      end
      checks++;
      if (exp_idx != 8) begin
         errors++;
         $display("[TB] FAIL bp_timeout got %0d beats want 8", exp_idx);
      end
      step();
      dma_data_ready_and_i = 1'b1;
      #1;
      checks++;
      if (dma_data_v_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_done_v got %b want 0", dma_data_v_o);
      end
   endtask

   task automatic test_alias();
      step();
      dma_pkt_i            = {1'b0, 28'h2040};
      dma_pkt_v_i          = 1'b1;
      dma_data_ready_and_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL alias_pkt_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         #1;
         checks++;
         if (dma_data_v_o !== 1'b1 || dma_data_o !== blk40(i)) begin
            errors++;
            $display("[TB] FAIL alias_beat%0d got v=%b d=%h want v=1 d=%h", i, dma_data_v_o, dma_data_o, blk40(i));
         end
      end
   endtask

   task automatic test_pkt_hold();
      step();
      dma_pkt_i   = {1'b1, 28'h80};
      dma_pkt_v_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_wr_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         dma_pkt_i    = {1'b0, 28'h80};
         dma_data_i   = blk80(i);
         dma_data_v_i = 1'b1;
         #1;
         checks++;
         if (dma_pkt_yumi_o !== 1'b0 || dma_data_yumi_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_beat%0d got pkt_yumi=%b data_yumi=%b want 0 1", i, dma_pkt_yumi_o, dma_data_yumi_o);
         end
      end
      step();
      dma_data_v_i = 1'b0;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_next_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         #1;
         checks++;
         if (dma_data_v_o !== 1'b1 || dma_data_o !== blk80(i)) begin
            errors++;
            $display("[TB] FAIL hold_rd%0d got v=%b d=%h want v=1 d=%h", i, dma_data_v_o, dma_data_o, blk80(i));
         end
      end
   endtask

   task automatic test_reset_mid_read();
      step();
      dma_pkt_i            = {1'b0, 28'h40};
      dma_pkt_v_i          = 1'b1;
      dma_data_ready_and_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         step();
      end
      #1;
      checks++;
      if (dma_data_v_o !== 1'b1 || dma_data_o !== blk40(3)) begin
         errors++;
         $display("[TB] FAIL mid_beat3 got v=%b d=%h want v=1 d=%h", dma_data_v_o, dma_data_o, blk40(3));
      end
      reset_n_i = 1'b0;
      #1;
      checks++;
      if (dma_data_v_o !== 1'b0 || dma_data_o !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset got v=%b d=%h want v=0 d=0", dma_data_v_o, dma_data_o);
      end
      step();
      reset_n_i = 1'b1;
      step();
      dma_pkt_i   = {1'b0, 28'h80};
      dma_pkt_v_i = 1'b1;
      #1;
      checks++;
      if (dma_pkt_yumi_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_after_yumi got %b want 1", dma_pkt_yumi_o);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         dma_pkt_v_i = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         #1;
         checks++;
         if (dma_data_v_o !== 1'b1 || dma_data_o !== blk80(i)) begin
            errors++;
            $display("[TB] FAIL mid_after_rd%0d got v=%b d=%h want v=1 d=%h", i, dma_data_v_o, dma_data_o, blk80(i));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write_block();
      test_read_latency();
      test_read_backpressure();
      test_alias();
      test_pkt_hold();
      test_reset_mid_read();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
